sdp_accum_ram: RTL



---
 rtl/sdp_accum_ram_pkg.sv | 15 +
 rtl/sdp_accum_ram_if.sv | 31 +++
 rtl/sdp_accum_ram_ram.sv | 36 +++
 rtl/sdp_accum_ram.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/sdp_accum_ram_pkg.sv
// Shared types and default sizes for the spectrum accumulator and its neighbours
// (FFT front end, readout path).
package sdp_accum_ram_pkg;

    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_DRAIN,
        ACC_CLEAR
    } acc_state_e;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned ACC_WIDTH_DEF  = 32;
    localparam int unsigned BIN_COUNT_DEF  = 256;

endpackage

// File: rtl/sdp_accum_ram_if.sv
// Accumulate request and readout signals of the spectrum accumulator RAM.
interface sdp_accum_ram_if
    import sdp_accum_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int unsigned DEPTH      = BIN_COUNT_DEF
);
    localparam int unsigned ADDRW = $clog2(DEPTH);

    logic                  in_valid;
    logic                  in_ready;
    logic [ADDRW-1:0]      in_addr;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_first;
    logic                  rd_en;
    logic [ADDRW-1:0]      rd_addr;
    logic [ACC_WIDTH-1:0]  rd_data;
    logic                  rd_valid;

    modport master (
        output in_valid, in_addr, in_data, in_first, rd_en, rd_addr,
        input  in_ready, rd_data, rd_valid
    );

    modport slave (
        input  in_valid, in_addr, in_data, in_first, rd_en, rd_addr,
        output in_ready, rd_data, rd_valid
    );

endinterface

// File: rtl/sdp_accum_ram_ram.sv
// Single-clock RAM, one write port and two independent registered read-first
// read ports; read registers reset to zero, storage does not.
module sdp_ram_sync #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 256,
    localparam int unsigned ADDRW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [ADDRW-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             a_en,
    input  logic [ADDRW-1:0] a_addr,
    output logic [WIDTH-1:0] a_data,
    input  logic             b_en,
    input  logic [ADDRW-1:0] b_addr,
    output logic [WIDTH-1:0] b_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_data <= '0;
            b_data <= '0;
        end else begin
            if (a_en) a_data <= mem[a_addr];
            if (b_en) b_data <= mem[b_addr];
        end
    end

endmodule

// File: rtl/sdp_accum_ram.sv
// Spectrum accumulator: saturating read-modify-write per bin with same-address
// forwarding, independent readout port and a hardware clear sequencer.
module sdp_accum_ram
    import sdp_accum_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int unsigned DEPTH      = BIN_COUNT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    sdp_accum_ram_if.slave   bus,
    input  logic             clr_start,
    output logic             busy,
    output logic             ovf
);
    localparam int unsigned ADDRW = $clog2(DEPTH);

    acc_state_e state, state_n;
    logic [ADDRW-1:0] clr_cnt;
    logic accept;

    logic                  s1_valid;
    logic [ADDRW-1:0]      s1_addr;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_first;

    logic                  fwd_valid;
    logic [ADDRW-1:0]      fwd_addr;
    logic [ACC_WIDTH-1:0]  fwd_data;

    logic [ACC_WIDTH-1:0]  ram_a_data;
    logic [ACC_WIDTH-1:0]  operand;
    logic [ACC_WIDTH:0]    sum_ext;
    logic                  s1_sat;
    logic [ACC_WIDTH-1:0]  s1_wdata;

    logic                  we;
    logic [ADDRW-1:0]      waddr;
    logic [ACC_WIDTH-1:0]  wdata;

    assign accept = bus.in_valid && bus.in_ready;

    // The RAM read issued at accept misses the write of the immediately
    // preceding accept, so a same-address hit takes the value just written.
    always_comb begin
        operand  = (fwd_valid && (fwd_addr == s1_addr)) ? fwd_data : ram_a_data;
        sum_ext  = {1'b0, operand} + (ACC_WIDTH+1)'(s1_data);
        s1_sat   = !s1_first && sum_ext[ACC_WIDTH];
        s1_wdata = s1_first ? ACC_WIDTH'(s1_data)
                 : (s1_sat ? '1 : sum_ext[ACC_WIDTH-1:0]);
    end

    always_comb begin
        state_n      = state;
        bus.in_ready = (state == ACC_IDLE);
        busy         = (state != ACC_IDLE);
        we           = 1'b0;
        waddr        = s1_addr;
        wdata        = s1_wdata;
        case (state)
            ACC_IDLE:  if (clr_start) state_n = ACC_DRAIN;
            ACC_DRAIN: state_n = ACC_CLEAR;
            ACC_CLEAR: if (clr_cnt == ADDRW'(DEPTH-1)) state_n = ACC_IDLE;
            default:   state_n = ACC_IDLE;
        endcase
        if (state == ACC_CLEAR) begin
            we    = 1'b1;
            waddr = clr_cnt;
            wdata = '0;
        end else if (s1_valid) begin
            we = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ACC_IDLE;
            clr_cnt <= '0;
        end else begin
            state <= state_n;
            if (state == ACC_CLEAR) clr_cnt <= clr_cnt + 1'b1;
            else                    clr_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            s1_data   <= '0;
            s1_first  <= 1'b0;
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= '0;
        end else begin
            s1_valid  <= accept;
            if (accept) begin
                s1_addr  <= bus.in_addr;
                s1_data  <= bus.in_data;
                s1_first <= bus.in_first;
            end
            fwd_valid <= s1_valid;
            fwd_addr  <= s1_addr;
            fwd_data  <= s1_wdata;
        end
    end

    // Clearing in DRAIN too drops a saturation from the request drained into the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if ((state == ACC_IDLE && clr_start) || state == ACC_DRAIN) begin
            ovf <= 1'b0;
        end else if (s1_valid && s1_sat) begin
            ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.rd_valid <= 1'b0;
        else        bus.rd_valid <= bus.rd_en;
    end

    sdp_ram_sync #(
        .WIDTH(ACC_WIDTH),
        .DEPTH(DEPTH)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .a_en   (accept),
        .a_addr (bus.in_addr),
        .a_data (ram_a_data),
        .b_en   (bus.rd_en),
        .b_addr (bus.rd_addr),
        .b_data (bus.rd_data)
    );

endmodule
